tune_slew_nco: RTL and testbench

TUNE_SLEW_NCO -- requirements
Module: tune_slew_nco

---
 rtl/tune_slew_nco.sv | 89 ++++++++
 tb/tb_tune_slew_nco.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tune_slew_nco.sv
// Slew-limited tuning word feeding a 32-bit phase accumulator NCO.
// Latency: target registered, freq_word follows one edge later; no backpressure, runs every clk.
module tune_slew_nco #(
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       tune_word,
    input  logic              slew_en,
    input  logic [STEP_W-1:0] step,
    input  logic              tick,
    output logic [31:0]       freq_word,
    output logic [31:0]       phase,
    output logic              wrap,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE, SLEW} state_t;

    state_t      state, state_nxt;
    logic [31:0] tgt;
    logic [31:0] fw_nxt;
    logic [31:0] step_ext;
    logic [31:0] diff;
    logic        done_nxt;
    logic [32:0] acc_sum;

    assign step_ext = 32'(step);
    assign acc_sum  = {1'b0, phase} + {1'b0, freq_word};

    always_comb begin
        state_nxt = state;
        fw_nxt    = freq_word;
        done_nxt  = 1'b0;
        // Magnitude of the distance without modular wrap, so the ramp never crosses 0/max.
        diff      = (tgt > freq_word) ? (tgt - freq_word) : (freq_word - tgt);
        case (state)
            IDLE: begin
                if (tgt != freq_word) begin
                    if (slew_en && (step_ext != '0)) begin
                        state_nxt = SLEW;
                    end else begin
                        fw_nxt   = tgt;
                        done_nxt = 1'b1;
                    end
                end
            end
            SLEW: begin
                if (!slew_en || (step_ext == '0) || (diff == '0)) begin
                    fw_nxt    = tgt;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (diff <= step_ext) begin
                        fw_nxt    = tgt;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else if (tgt > freq_word) begin
                        fw_nxt = freq_word + step_ext;
                    end else begin
                        fw_nxt = freq_word - step_ext;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tgt       <= '0;
            freq_word <= '0;
            phase     <= '0;
            wrap      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            tgt       <= tune_word;
            freq_word <= fw_nxt;
            phase     <= acc_sum[31:0];
            wrap      <= acc_sum[32];
            done      <= done_nxt;
            busy      <= (state_nxt == SLEW);
        end
    end

endmodule

// File: tb/tb_tune_slew_nco.sv
// Directed and random checks of tune_slew_nco against an arithmetic reference model.
module tb_tune_slew_nco;

    localparam int     STEP_W = 16;
    localparam longint M32    = longint'(1) << 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [31:0]       tune_word;
    logic              slew_en;
    logic [STEP_W-1:0] step;
    logic              tick;
    logic [31:0]       freq_word;
    logic [31:0]       phase;
    logic              wrap;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    longint m_tgt, m_fw, m_phase;
    bit     m_wrap, m_done, m_slewing;

    tune_slew_nco #(.STEP_W(STEP_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tune_word (tune_word),
        .slew_en   (slew_en),
        .step      (step),
        .tick      (tick),
        .freq_word (freq_word),
        .phase     (phase),
        .wrap      (wrap),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tgt = 0; m_fw = 0; m_phase = 0;
        m_wrap = 0; m_done = 0; m_slewing = 0;
    endtask

    // Spec rules applied to the pre-edge state with plain signed arithmetic.
    task automatic model_edge(input longint tw, input bit se, input longint st, input bit tk);
        longint d, ad;
        m_phase = m_phase + m_fw;
        m_wrap  = (m_phase >= M32);
        m_phase = m_phase % M32;
        m_done  = 0;
        d  = m_tgt - m_fw;
        ad = (d < 0) ? -d : d;
        if (!m_slewing) begin
            if (d != 0) begin
                if (se && st != 0) m_slewing = 1;
                else begin m_fw = m_tgt; m_done = 1; end
            end
        end else if (!se || st == 0 || d == 0) begin
            m_fw = m_tgt; m_done = 1; m_slewing = 0;
        end else if (tk) begin
            if (ad <= st) begin m_fw = m_tgt; m_done = 1; m_slewing = 0; end
            else m_fw = m_fw + ((d > 0) ? st : -st);
        end
        m_tgt = tw;
    endtask

    task automatic check_all();
        chk("freq_word", freq_word, 32'(m_fw));
        chk("phase",     phase,     32'(m_phase));
        chk("wrap",      32'(wrap), 32'(m_wrap));
        chk("done",      32'(done), 32'(m_done));
        chk("busy",      32'(busy), 32'(m_slewing));
    endtask

    task automatic cycle();
        longint tw, st;
        bit se, tk, rst;
        tw = longint'(tune_word); st = longint'(step);
        se = slew_en; tk = tick; rst = reset_n;
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else model_edge(tw, se, st, tk);
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_freq_word", freq_word, 32'h0);
        chk("rst_phase",     phase,     32'h0);
        chk("rst_flags",     {29'b0, wrap, done, busy}, 32'h0);
        cycle();
        reset_n = 1'b1;
    endtask

    logic [31:0] exp_v [3];

    initial begin
        reset_n = 1'b0; tune_word = '0; slew_en = 1'b0; step = '0; tick = 1'b0;
        do_reset();

        // Direct load: two edges from change to freq_word/done.
        tune_word = 32'h1000_0000;
        cycle();
        chk("direct_fw_n", freq_word, 32'h0);
        cycle();
        chk("direct_fw", freq_word, 32'h1000_0000);
        chk("direct_done", 32'(done), 32'h1);
        chk("direct_busy", 32'(busy), 32'h0);
        cycle();
        chk("direct_done_clr", 32'(done), 32'h0);

        // Accumulator and wrap.
        do_reset();
        tune_word = 32'h4000_0000;
        cycle(); cycle();
        chk("acc_phase0", phase, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk("acc_phase", phase, 32'(longint'(k) * 64'h4000_0000));
            chk("acc_wrap", 32'(wrap), (k == 4) ? 32'h1 : 32'h0);
        end
        cycle();
        chk("acc_wrap_once", 32'(wrap), 32'h0);

        // Up-ramp with ticks every 4 clocks.
        do_reset();
        slew_en = 1'b1; step = 16'h100; tune_word = 32'h250;
        cycle(); cycle();
        chk("up_busy_entry", 32'(busy), 32'h1);
        chk("up_fw_entry", freq_word, 32'h0);
        exp_v[0] = 32'h100; exp_v[1] = 32'h200; exp_v[2] = 32'h250;
        for (int k = 0; k < 3; k++) begin
            tick = 1'b0;
            cycle(); cycle(); cycle();
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            chk("up_fw", freq_word, exp_v[k]);
            chk("up_done", 32'(done), (k == 2) ? 32'h1 : 32'h0);
            chk("up_busy", 32'(busy), (k == 2) ? 32'h0 : 32'h1);
        end
        cycle();

        // Down-ramp with retarget, no underflow.
        do_reset();
        slew_en = 1'b0; tune_word = 32'h1000;
        cycle(); cycle();
        slew_en = 1'b1; step = 16'h400; tune_word = 32'h0;
        cycle(); cycle();
        chk("down_busy", 32'(busy), 32'h1);
        tick = 1'b1;
        cycle(); cycle();
        chk("down_fw_two_ticks", freq_word, 32'h800);
        tick = 1'b0; tune_word = 32'hA00;
        cycle();
        tick = 1'b1;
        cycle();
        chk("down_fw_retarget", freq_word, 32'hA00);
        chk("down_done", 32'(done), 32'h1);
        tick = 1'b0;
        cycle();

        // Abort by dropping slew_en, then step=0 as direct load.
        tune_word = 32'h5000; step = 16'h100;
        cycle(); cycle();
        tick = 1'b1;
        cycle();
        chk("abort_fw_mid", freq_word, 32'hB00);
        tick = 1'b0; slew_en = 1'b0;
        cycle();
        chk("abort_fw", freq_word, 32'h5000);
        chk("abort_done", 32'(done), 32'h1);
        chk("abort_busy", 32'(busy), 32'h0);
        slew_en = 1'b1; step = '0; tune_word = 32'h7000;
        cycle(); cycle();
        chk("step0_fw", freq_word, 32'h7000);
        chk("step0_busy", 32'(busy), 32'h0);

        // Reset mid-ramp restarts from 0.
        step = 16'h100; tune_word = 32'h300;
        cycle(); cycle();
        tick = 1'b1;
        cycle();
        chk("rst_ramp_fw_mid", freq_word, 32'h6F00);
        do_reset();
        cycle();
        chk("rst_ramp_idle", 32'(busy), 32'h0);
        cycle();
        chk("rst_ramp_busy", 32'(busy), 32'h1);
        cycle();
        chk("rst_ramp_fw", freq_word, 32'h100);

        // Random traffic against the model.
        step = 16'h200;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: tune_word = $urandom_range(0, 32'h4000);
                    1: tune_word = 32'hFFFF_C000 + $urandom_range(0, 32'h3FFF);
                    2: tune_word = $urandom();
                    default: tune_word = 32'(m_fw);
                endcase
            end
            slew_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0)
                step = ($urandom_range(0, 3) == 0) ? '0 : STEP_W'($urandom());
            tick = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
